// File: rtl/ppu_oam_pkg.sv
// Shared PPU definitions for the OAMADDR/OAMDATA register pair.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package ppu_oam_pkg;

  localparam logic [2:0] REG_OAMADDR   = 3'd3;
  localparam logic [2:0] REG_OAMDATA   = 3'd4;
  localparam logic       RW_READ       = 1'b1;
  localparam logic       RW_WRITE      = 1'b0;
  localparam logic [7:0] OAM_ATTR_MASK = 8'hE3;

  typedef struct packed {
    logic       sel;
    logic [2:0] idx;
  } bus_dec_t;

  function automatic bus_dec_t bus_decode(input logic [2:0] addr_hi, input logic [2:0] addr_lo);
    bus_dec_t d;
    d.sel = (addr_hi == 3'b001);
    d.idx = addr_lo;
    return d;
  endfunction

  // Bits [4:2] of every attribute byte (OAMADDR[1:0]==2) read back as zero.
  function automatic logic [7:0] oam_store_val(input logic [1:0] byte_sel, input logic [7:0] dat);
    return (byte_sel == 2'd2) ? (dat & OAM_ATTR_MASK) : dat;
  endfunction

endpackage

// File: rtl/ppu_oam_ram.sv
// 256x8 sprite RAM: one falling-edge write port, two asynchronous read ports.
// Latency: write visible on both read ports after the writing edge; reads are combinational.
// Backpressure: none, accepts a write on every enabled edge.
module ppu_oam_ram (
  input  logic       i_clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_dat,
  input  logic [7:0] cpu_addr,
  output logic [7:0] cpu_dat,
  input  logic [7:0] spr_addr,
  output logic [7:0] spr_dat
);

  logic [7:0] mem [256];

  // Contents are deliberately not reset.
  always_ff @(negedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign cpu_dat = mem[cpu_addr];
  assign spr_dat = mem[spr_addr];

endmodule

// File: rtl/ppu_oam.sv
// PPU OAM block: $2003/$2004 decode, OAMADDR pointer, sprite RAM and renderer read port.
// Latency: writes commit on the falling edge; $2004 reads and renderer reads are combinational.
// Backpressure: none, every enabled bus cycle is accepted.
module ppu_oam
  import ppu_oam_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  input  logic        i_rw,
  input  logic [15:0] i_address,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_data_oe,
  input  logic        i_rendering,
  input  logic        i_oamaddr_clear,
  input  logic [7:0]  i_sprite_addr,
  output logic [7:0]  o_sprite_data,
  output logic [7:0]  o_oamaddr
);

  bus_dec_t   dec;
  logic       oamaddr_wr_vld;
  logic       oamdata_wr_vld;
  logic       oamdata_rd_vld;
  logic       ram_we;
  logic [7:0] ram_wdat;
  logic [7:0] cpu_rd_dat;
  logic [7:0] oamaddr_q;
  logic [7:0] oamaddr_nxt;
  logic       unused_addr_bits;

  assign dec              = bus_decode(i_address[15:13], i_address[2:0]);
  assign unused_addr_bits = ^i_address[12:3];

  assign oamaddr_wr_vld = i_clk_en & (i_rw == RW_WRITE) & dec.sel & (dec.idx == REG_OAMADDR);
  assign oamdata_wr_vld = i_clk_en & (i_rw == RW_WRITE) & dec.sel & (dec.idx == REG_OAMDATA);
  assign oamdata_rd_vld = i_clk_en & (i_rw == RW_READ)  & dec.sel & (dec.idx == REG_OAMDATA);

  // During rendering the write is dropped and only the sprite index advances.
  assign ram_we   = oamdata_wr_vld & ~i_rendering;
  assign ram_wdat = oam_store_val(oamaddr_q[1:0], i_data);

  always_comb begin
    oamaddr_nxt = oamaddr_q;
    if (oamaddr_wr_vld) begin
      oamaddr_nxt = i_data;
    end else if (oamdata_wr_vld) begin
      if (i_rendering) begin
        oamaddr_nxt = {oamaddr_q[7:2] + 6'd1, oamaddr_q[1:0]};
      end else begin
        oamaddr_nxt = oamaddr_q + 8'd1;
      end
    end
    // The renderer's clear overrides any CPU-side update on the same edge.
    if (i_oamaddr_clear) begin
      oamaddr_nxt = 8'h00;
    end
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      oamaddr_q <= 8'h00;
    end else begin
      oamaddr_q <= oamaddr_nxt;
    end
  end

  ppu_oam_ram u_ram (
    .i_clk    (i_clk),
    .wr_en    (ram_we),
    .wr_addr  (oamaddr_q),
    .wr_dat   (ram_wdat),
    .cpu_addr (oamaddr_q),
    .cpu_dat  (cpu_rd_dat),
    .spr_addr (i_sprite_addr),
    .spr_dat  (o_sprite_data)
  );

  assign o_data_oe = oamdata_rd_vld & i_reset_n;
  assign o_data    = o_data_oe ? cpu_rd_dat : 8'h00;
  assign o_oamaddr = oamaddr_q;

endmodule

// File: tb/tb_ppu_oam.sv
// Self-checking bench for ppu_oam: table-driven bus vectors, scoreboard on $2004 reads,
// plus hand sequences for DMA, rendering, clear and asynchronous reset.
module tb_ppu_oam;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_clk_en;
  logic        i_rw;
  logic [15:0] i_address;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        o_data_oe;
  logic        i_rendering;
  logic        i_oamaddr_clear;
  logic [7:0]  i_sprite_addr;
  logic [7:0]  o_sprite_data;
  logic [7:0]  o_oamaddr;

  ppu_oam dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_clk_en        (i_clk_en),
    .i_rw            (i_rw),
    .i_address       (i_address),
    .i_data          (i_data),
    .o_data          (o_data),
    .o_data_oe       (o_data_oe),
    .i_rendering     (i_rendering),
    .i_oamaddr_clear (i_oamaddr_clear),
    .i_sprite_addr   (i_sprite_addr),
    .o_sprite_data   (o_sprite_data),
    .o_oamaddr       (o_oamaddr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of OAM and OAMADDR, with a known-mask for never-written bytes.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_addr;

  typedef struct {
    logic [7:0] dat;
    logic       oe;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  typedef struct {
    bit          en;
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_rd;
    bit          exp_oe;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  // Drive one bus cycle; returns at the mid-cycle sample point ahead of the falling edge.
  task automatic drive(input bit en, input bit rw, input logic [15:0] addr, input logic [7:0] dat,
                       input bit rend, input bit clr);
    @(posedge i_clk);
    #1;
    i_clk_en        = en;
    i_rw            = rw;
    i_address       = addr;
    i_data          = dat;
    i_rendering     = rend;
    i_oamaddr_clear = clr;
    #2;
  endtask

  task automatic end_cycle();
    @(negedge i_clk);
    #1;
    i_clk_en        = 1'b0;
    i_rw            = 1'b1;
    i_oamaddr_clear = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit rw, input logic [15:0] addr, input logic [7:0] dat,
                            input bit rend, input bit clr);
    logic [7:0] na;
    na = m_addr;
    if (en && !rw && addr[15:13] == 3'b001) begin
      if (addr[2:0] == 3'd3) begin
        na = dat;
      end else if (addr[2:0] == 3'd4) begin
        if (!rend) begin
          m_mem[m_addr]   = (m_addr[1:0] == 2'd2) ? {dat[7:5], 3'b000, dat[1:0]} : dat;
          m_known[m_addr] = 1'b1;
          na = m_addr + 8'd1;
        end else begin
          na = {m_addr[7:2] + 6'd1, m_addr[1:0]};
        end
      end
    end
    if (clr) na = 8'h00;
    m_addr = na;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] dat, input bit en = 1'b1,
                    input bit rend = 1'b0, input bit clr = 1'b0);
    logic [7:0] a_before;
    a_before      = m_addr;
    i_sprite_addr = a_before;
    drive(en, 1'b0, addr, dat, rend, clr);
    // Renderer sees the pre-write value during the writing cycle.
    if (m_known[a_before]) check("rdr_old", o_sprite_data, m_mem[a_before]);
    model_step(en, 1'b0, addr, dat, rend, clr);
    end_cycle();
    check("oamaddr_wr", o_oamaddr, m_addr);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [7:0] exp_dat, input bit exp_oe, input bit chk_dat);
    rd_exp_t e;
    rd_exp_t got;
    e.dat = exp_dat;
    e.oe  = exp_oe;
    sb_q.push_back(e);
    drive(1'b1, 1'b1, addr, 8'h00, 1'b0, 1'b0);
    got = sb_q.pop_front();
    check("rd_oe", {7'd0, o_data_oe}, {7'd0, got.oe});
    if (chk_dat) check("rd_dat", o_data, got.dat);
    end_cycle();
    check("oamaddr_rd", o_oamaddr, m_addr);
  endtask

  task automatic rdr_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    i_sprite_addr = a;
    #1;
    check(name, o_sprite_data, exp);
  endtask

  vec_t tbl[$];

  initial begin
    i_reset_n       = 1'b0;
    i_clk_en        = 1'b0;
    i_rw            = 1'b1;
    i_address       = 16'h0000;
    i_data          = 8'h00;
    i_rendering     = 1'b0;
    i_oamaddr_clear = 1'b0;
    i_sprite_addr   = 8'h00;
    m_addr          = 8'h00;
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = 1'b0;
    end

    #12;
    check("rst_oamaddr", o_oamaddr, 8'h00);
    check("rst_oe", {7'd0, o_data_oe}, 8'h00);
    check("rst_data", o_data, 8'h00);
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;

    // Reads enable the driver but never advance OAMADDR.
    rd(16'h2004, 8'h00, 1'b1, 1'b0);
    wr(16'h2003, 8'h10);
    rd(16'h2004, 8'h00, 1'b1, 1'b0);
    check("rd_noinc1", o_oamaddr, 8'h10);
    rd(16'h2004, 8'h00, 1'b1, 1'b0);
    check("rd_noinc2", o_oamaddr, 8'h10);

    // Emulated OAM DMA from $F0, value i+1 truncated to 8 bits.
    wr(16'h2003, 8'hF0);
    for (int i = 0; i < 256; i++) begin
      wr(16'h2004, 8'(i + 1));
    end
    check("dma_end_addr", o_oamaddr, 8'hF0);
    @(posedge i_clk);
    #1;
    rdr_chk("dma_f0", 8'hF0, 8'h01);
    rdr_chk("dma_ef", 8'hEF, 8'h00);
    rdr_chk("dma_f6_attr", 8'hF6, 8'h03);
    rdr_chk("dma_04", 8'h04, 8'h15);

    // Bus vectors: writes check the resulting OAMADDR, reads check o_data/o_data_oe.
    tbl = '{
      '{1, 0, 16'h2003, 8'h00, 8'h00, 8'h00, 0},
      '{1, 0, 16'h2004, 8'h20, 8'h01, 8'h00, 0},
      '{1, 0, 16'h2004, 8'h41, 8'h02, 8'h00, 0},
      '{1, 0, 16'h2004, 8'hFF, 8'h03, 8'h00, 0},
      '{1, 0, 16'h2004, 8'h80, 8'h04, 8'h00, 0},
      '{1, 1, 16'h3FFC, 8'h00, 8'h04, 8'h15, 1},
      '{1, 0, 16'h200B, 8'h00, 8'h00, 8'h00, 0},
      '{1, 1, 16'h2004, 8'h00, 8'h00, 8'h20, 1},
      '{1, 1, 16'h2C04, 8'h00, 8'h00, 8'h20, 1},
      '{1, 0, 16'h2003, 8'h02, 8'h02, 8'h00, 0},
      '{1, 1, 16'h2004, 8'h00, 8'h02, 8'hE3, 1},
      '{1, 0, 16'h4004, 8'h99, 8'h02, 8'h00, 0},
      '{1, 0, 16'h2005, 8'h12, 8'h02, 8'h00, 0},
      '{0, 0, 16'h2003, 8'h77, 8'h02, 8'h00, 0},
      '{1, 1, 16'h2003, 8'h00, 8'h02, 8'h00, 0},
      '{1, 1, 16'h6004, 8'h00, 8'h02, 8'h00, 0}
    };
    foreach (tbl[k]) begin
      if (tbl[k].rw) rd(tbl[k].addr, tbl[k].exp_rd, tbl[k].exp_oe, 1'b1);
      else           wr(tbl[k].addr, tbl[k].data, tbl[k].en);
      check("tbl_addr", o_oamaddr, tbl[k].exp_addr);
    end
    @(posedge i_clk);
    #1;
    rdr_chk("tbl_oam0", 8'h00, 8'h20);
    rdr_chk("tbl_oam1", 8'h01, 8'h41);
    rdr_chk("tbl_oam2", 8'h02, 8'hE3);
    rdr_chk("tbl_oam3", 8'h03, 8'h80);

    // Rendering-time write: RAM untouched, only OAMADDR[7:2] advances.
    wr(16'h2003, 8'hFD);
    wr(16'h2004, 8'h55, 1'b1, 1'b1);
    check("rend_addr", o_oamaddr, 8'h01);
    @(posedge i_clk);
    #1;
    rdr_chk("rend_ram", 8'hFD, 8'h0E);

    // Clear on the same edge as a data write: store at old address, end at 0.
    wr(16'h2003, 8'h08);
    wr(16'h2004, 8'h77, 1'b1, 1'b0, 1'b1);
    check("clr_wr_addr", o_oamaddr, 8'h00);
    @(posedge i_clk);
    #1;
    rdr_chk("clr_wr_ram", 8'h08, 8'h77);
    wr(16'h2003, 8'h5A, 1'b1, 1'b0, 1'b1);
    check("clr_2003", o_oamaddr, 8'h00);
    wr(16'h2003, 8'h20);
    wr(16'h2004, 8'h11, 1'b0, 1'b0, 1'b1);
    check("clr_noen", o_oamaddr, 8'h00);

    // Asynchronous reset in the middle of a cycle.
    wr(16'h2003, 8'h37);
    check("pre_rst", o_oamaddr, 8'h37);
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    m_addr = 8'h00;
    check("async_rst", o_oamaddr, 8'h00);
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    rdr_chk("rst_keep0", 8'h00, 8'h20);
    rdr_chk("rst_keep2", 8'h02, 8'hE3);
    rdr_chk("rst_keep8", 8'h08, 8'h77);
    rd(16'h2004, 8'h20, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end

endmodule
